// File: rtl/fifo_pkg.sv
// Shared constants and types for the 128-bit FIFO and its write-side packer.
package fifo_pkg;

   localparam int FIFO_DW   = 128;
   localparam int FIFO_IN_W = 32;

   typedef logic [FIFO_DW-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_wr_packer.sv
// Packs narrow valid/ready beats little-endian into full FIFO words and writes them.
// Optional early word close (s_last) is compiled in with FIFO_PACKER_FLUSH_EN.
module fifo_wr_packer
   import fifo_pkg::*;
#(
   parameter int IN_W  = FIFO_IN_W,
   parameter int OUT_W = FIFO_DW,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [IN_W-1:0]  s_data,
`ifdef FIFO_PACKER_FLUSH_EN
   input  logic             s_last,
`endif
   input  logic             o_full,
   input  logic             o_alm_full,
   output logic             i_wren,
   output logic [OUT_W-1:0] i_wrdata,
   output logic [CNT_W-1:0] wr_count,
   output logic             busy
);

   localparam int LANES  = OUT_W / IN_W;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   if (((OUT_W % IN_W) != 0) || (LANES < 2)) begin : g_bad_widths
      $error("fifo_wr_packer: OUT_W must be a multiple of IN_W with OUT_W/IN_W >= 2");
   end

   logic [LANE_W-1:0] lane_q,   lane_d;
   logic [OUT_W-1:0]  stage_q,  stage_d;
   logic [OUT_W-1:0]  hold_q,   hold_d;
   logic              pend_q,   pend_d;
   logic              wren_q,   wren_d;
   logic [OUT_W-1:0]  wrdata_q, wrdata_d;
   logic [CNT_W-1:0]  count_q,  count_d;

   logic              at_last;
   logic              last_beat;
   logic              issue;
   logic              accept;
   logic              close;
   logic [OUT_W-1:0]  merged;

`ifdef FIFO_PACKER_FLUSH_EN
   assign last_beat = s_last;
`else
   assign last_beat = 1'b0;
`endif

   // Handshake: a beat transfers on a rising edge where s_valid and s_ready are
   // both high; s_ready only drops when the beat would close a word while the
   // previous word is still held and cannot be issued this cycle.
   always_comb begin
      at_last = (lane_q == LAST_LANE);
      // The flags lag our own write by a cycle, so a write in flight plus
      // almost-full is treated as full.
      issue   = pend_q & ~o_full & ~(wren_q & o_alm_full);
      s_ready = ~rst & ~(pend_q & (at_last | last_beat) & ~issue);
      accept  = s_valid & s_ready;
      close   = accept & (at_last | last_beat);

      merged = stage_q;
      for (int i = 0; i < LANES; i++) begin
         if (lane_q == LANE_W'(i)) begin
            merged[i*IN_W +: IN_W] = s_data;
         end
      end
   end

   always_comb begin
      lane_d   = lane_q;
      stage_d  = stage_q;
      hold_d   = hold_q;
      pend_d   = pend_q;
      wren_d   = issue;
      wrdata_d = wrdata_q;
      count_d  = count_q;

      if (issue) begin
         wrdata_d = hold_q;
         count_d  = count_q + CNT_W'(1);
         pend_d   = 1'b0;
      end

      if (accept) begin
         if (close) begin
            // Staging restarts from zero so a short word has zero upper lanes.
            hold_d  = merged;
            stage_d = '0;
            lane_d  = '0;
            pend_d  = 1'b1;
         end else begin
            stage_d = merged;
            lane_d  = lane_q + LANE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q   <= '0;
         stage_q  <= '0;
         hold_q   <= '0;
         pend_q   <= 1'b0;
         wren_q   <= 1'b0;
         wrdata_q <= '0;
         count_q  <= '0;
      end else begin
         lane_q   <= lane_d;
         stage_q  <= stage_d;
         hold_q   <= hold_d;
         pend_q   <= pend_d;
         wren_q   <= wren_d;
         wrdata_q <= wrdata_d;
         count_q  <= count_d;
      end
   end

   assign i_wren   = wren_q;
   assign i_wrdata = wrdata_q;
   assign wr_count = count_q;
   assign busy     = (lane_q != '0) | pend_q | wren_q;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer at default widths (4 lanes of 32 bits).
module tb_fifo_wr_packer;

   localparam int IN_W  = 32;
   localparam int OUT_W = 128;
   localparam int CNT_W = 32;

   logic             clk;
   logic             rst;
   logic             s_valid;
   logic             s_ready;
   logic [IN_W-1:0]  s_data;
   logic             s_last;
   logic             o_full;
   logic             o_alm_full;
   logic             i_wren;
   logic [OUT_W-1:0] i_wrdata;
   logic [CNT_W-1:0] wr_count;
   logic             busy;

   fifo_wr_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
`ifdef FIFO_PACKER_FLUSH_EN
      .s_last     (s_last),
`endif
      .o_full     (o_full),
      .o_alm_full (o_alm_full),
      .i_wren     (i_wren),
      .i_wrdata   (i_wrdata),
      .wr_count   (wr_count),
      .busy       (busy)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   logic [OUT_W-1:0] exp_q[$];
   int               n_checks;
   int               n_pass;
   int               nwrites;
   int               ready_low;
   int               cyc;
   int               last_wr_cyc;
   logic             chk_spacing;
   logic             full_seen;
   logic             prev_wren;
   logic [OUT_W-1:0] prev_data;

   typedef struct {
      logic        vld;
      logic [31:0] data;
      logic        exp_ready;
      logic        exp_wren;
      logic        exp_busy;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vec[7];

   task automatic check(input string name, input logic ok,
                        input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [OUT_W-1:0] mk_word(input logic [31:0] b);
      return {b + 32'd3, b + 32'd2, b + 32'd1, b};
   endfunction

   // Sample outputs at the falling edge and run the write monitor.
   task automatic sample();
      logic [OUT_W-1:0] e;
      @(negedge clk);
      cyc++;
      if (i_wren) begin
         nwrites++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", 1'b0, i_wrdata, '0);
         end else begin
            e = exp_q.pop_front();
            check("wr_data", i_wrdata == e, i_wrdata, e);
         end
         check("wren_saw_full", !full_seen, 128'(full_seen), 128'(0));
         if (prev_wren) check("wren_repeat_data", i_wrdata != prev_data, i_wrdata, prev_data);
         if (chk_spacing && last_wr_cyc >= 0)
            check("wr_spacing", (cyc - last_wr_cyc) == 4, 128'(cyc - last_wr_cyc), 128'(4));
         last_wr_cyc = cyc;
      end
      prev_wren = i_wren;
      prev_data = i_wrdata;
      if (s_valid && !s_ready && !rst) ready_low++;
      full_seen = o_full;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) begin
         sample();
         advance();
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic last);
      int   n;
      logic acc;
      n       = 0;
      acc     = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      while (!acc) begin
         sample();
         acc = s_ready;
         advance();
         n++;
         if (!acc && n > 100) begin
            check("beat_timeout", 1'b0, 128'(n), 128'(100));
            acc = 1'b1;
         end
      end
      s_last = 1'b0;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      s_valid    = 1'b0;
      s_data     = '0;
      s_last     = 1'b0;
      o_alm_full = 1'b0;
      exp_q.delete();
      nwrites     = 0;
      ready_low   = 0;
      last_wr_cyc = -1;
      prev_wren   = 1'b0;
      sample();
      check("rst_ready", s_ready == 1'b0, 128'(s_ready), 128'(0));
      check("rst_wren", i_wren == 1'b0, 128'(i_wren), 128'(0));
      check("rst_wrdata", i_wrdata == '0, i_wrdata, '0);
      check("rst_count", wr_count == '0, 128'(wr_count), 128'(0));
      check("rst_busy", busy == 1'b0, 128'(busy), 128'(0));
      advance();
      rst = 1'b0;
   endtask

   initial begin
      int   bi;
      logic acc;
      n_checks    = 0;
      n_pass      = 0;
      cyc         = 0;
      chk_spacing = 1'b0;
      full_seen   = 1'b0;
      prev_data   = '0;
      o_full      = 1'b0;

      vec[0] = '{1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0, 32'd0};
      vec[1] = '{1'b1, 32'h22222222, 1'b1, 1'b0, 1'b1, 32'd0};
      vec[2] = '{1'b1, 32'h33333333, 1'b1, 1'b0, 1'b1, 32'd0};
      vec[3] = '{1'b1, 32'h44444444, 1'b1, 1'b0, 1'b1, 32'd0};
      vec[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'd0};
      vec[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'd1};
      vec[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'd1};

      // basic pack, table driven
      do_reset();
      exp_q.push_back({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
      for (int i = 0; i < 7; i++) begin
         s_valid = vec[i].vld;
         s_data  = vec[i].data;
         sample();
         check($sformatf("vec%0d_ready", i), s_ready == vec[i].exp_ready, 128'(s_ready), 128'(vec[i].exp_ready));
         check($sformatf("vec%0d_wren", i), i_wren == vec[i].exp_wren, 128'(i_wren), 128'(vec[i].exp_wren));
         check($sformatf("vec%0d_busy", i), busy == vec[i].exp_busy, 128'(busy), 128'(vec[i].exp_busy));
         check($sformatf("vec%0d_count", i), wr_count == vec[i].exp_cnt, 128'(wr_count), 128'(vec[i].exp_cnt));
         advance();
      end
      check("basic_nwrites", nwrites == 1, 128'(nwrites), 128'(1));

      // streaming: 64 beats, one write every 4 cycles
      do_reset();
      for (int n = 0; n < 16; n++) exp_q.push_back(mk_word(32'(4 * n)));
      chk_spacing = 1'b1;
      for (int b = 0; b < 64; b++) send_beat(32'(b), 1'b0);
      idle(6);
      chk_spacing = 1'b0;
      check("stream_ready_low", ready_low == 0, 128'(ready_low), 128'(0));
      check("stream_nwrites", nwrites == 16, 128'(nwrites), 128'(16));
      check("stream_count", wr_count == 32'd16, 128'(wr_count), 128'(16));
      check("stream_exp_left", exp_q.size() == 0, 128'(exp_q.size()), 128'(0));

      // backpressure: o_full from reset
      o_full = 1'b1;
      do_reset();
      for (int w = 0; w < 3; w++) exp_q.push_back(mk_word(32'h100 + 32'(4 * w)));
      bi      = 0;
      s_valid = 1'b1;
      repeat (20) begin
         s_data = 32'h100 + 32'(bi);
         sample();
         acc = s_ready;
         advance();
         if (acc) bi++;
      end
      check("bp_accepted", bi == 7, 128'(bi), 128'(7));
      check("bp_no_write", nwrites == 0, 128'(nwrites), 128'(0));
      sample();
      check("bp_ready_low", s_ready == 1'b0, 128'(s_ready), 128'(0));
      check("bp_busy", busy == 1'b1, 128'(busy), 128'(1));
      advance();
      o_full = 1'b0;
      for (int b = 7; b < 12; b++) send_beat(32'h100 + 32'(b), 1'b0);
      idle(8);
      check("bp_nwrites", nwrites == 3, 128'(nwrites), 128'(3));
      check("bp_count", wr_count == 32'd3, 128'(wr_count), 128'(3));

      // flag lag: almost-full while a write is in flight and a word is pending
      o_full = 1'b1;
      do_reset();
      exp_q.push_back(mk_word(32'h200));
      exp_q.push_back(mk_word(32'h204));
      for (int b = 0; b < 7; b++) send_beat(32'h200 + 32'(b), 1'b0);
      s_valid = 1'b1;
      s_data  = 32'h207;
      o_full  = 1'b0;
      sample();
      check("lag_ready_release", s_ready == 1'b1, 128'(s_ready), 128'(1));
      advance();
      s_valid    = 1'b0;
      o_alm_full = 1'b1;
      sample();
      check("lag_wren_first", i_wren == 1'b1, 128'(i_wren), 128'(1));
      advance();
      sample();
      check("lag_wren_gap", i_wren == 1'b0, 128'(i_wren), 128'(0));
      advance();
      sample();
      check("lag_wren_second", i_wren == 1'b1, 128'(i_wren), 128'(1));
      advance();
      o_alm_full = 1'b0;
      idle(4);
      check("lag_count", wr_count == 32'd2, 128'(wr_count), 128'(2));
      check("lag_exp_left", exp_q.size() == 0, 128'(exp_q.size()), 128'(0));

      // reset mid-word drops the partial word
      do_reset();
      send_beat(32'h1, 1'b0);
      send_beat(32'h2, 1'b0);
      s_valid = 1'b0;
      rst     = 1'b1;
      sample();
      check("midrst_busy", busy == 1'b0, 128'(busy), 128'(0));
      check("midrst_ready", s_ready == 1'b0, 128'(s_ready), 128'(0));
      advance();
      rst = 1'b0;
      exp_q.push_back({32'hD, 32'hC, 32'hB, 32'hA});
      for (int b = 0; b < 4; b++) send_beat(32'hA + 32'(b), 1'b0);
      idle(6);
      check("midrst_nwrites", nwrites == 1, 128'(nwrites), 128'(1));
      check("midrst_count", wr_count == 32'd1, 128'(wr_count), 128'(1));
      check("midrst_idle", busy == 1'b0, 128'(busy), 128'(0));

`ifdef FIFO_PACKER_FLUSH_EN
      // early close, then the next beat starts a fresh word in lane 0
      do_reset();
      exp_q.push_back({32'h0, 32'h0, 32'h6, 32'h5});
      exp_q.push_back({32'hA, 32'h9, 32'h8, 32'h7});
      send_beat(32'h5, 1'b0);
      send_beat(32'h6, 1'b1);
      for (int b = 7; b < 11; b++) send_beat(32'(b), 1'b0);
      idle(6);
      check("flush_nwrites", nwrites == 2, 128'(nwrites), 128'(2));
      check("flush_count", wr_count == 32'd2, 128'(wr_count), 128'(2));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
